// File: rtl/mem_stage_pkg.sv
// Shared opcodes, run-state value and FSM encoding for the memory stage.
// Imported by mem_stage, mem_wait_timer and the testbench.
package mem_stage_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_ADD   = 5'b00100;

    localparam logic        EXEC = 1'b1;
    localparam logic [15:0] NOP  = 16'h0000;
    localparam logic [15:0] ERR_DATA = 16'hFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_fsm_e;

    function automatic logic is_load(input logic [15:0] ir);
        return ir[15:11] == OP_LOAD;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the memory stage and data memory.
// master = pipeline stage, slave = memory.
interface mem_stage_if #(
    parameter int ADDR_W = 8
);

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [15:0]       d_dataout;
    logic [15:0]       d_datain;
    logic              d_ready;

    modport master (
        output d_req,
        output d_we,
        output d_addr,
        output d_dataout,
        input  d_datain,
        input  d_ready
    );

    modport slave (
        input  d_req,
        input  d_we,
        input  d_addr,
        input  d_dataout,
        output d_datain,
        output d_ready
    );

endinterface

// File: rtl/mem_stage_wait_timer.sv
// Wait-cycle counter for the memory stage; expired flags the last allowed
// wait cycle. Only built when MEM_TIMEOUT_EN is defined.
module mem_wait_timer
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CW =
        (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: LOAD/STORE over a ready handshake, stall
// while outstanding. MEM_TIMEOUT_EN adds a wait-cycle abort with mem_err.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                state,
    input  logic [15:0]         mem_ir,
    input  logic [15:0]         reg_C,
    input  logic                dw,
    input  logic [15:0]         smdr1,
    mem_stage_if.master         dmem,
    output logic                stall,
    output logic [15:0]         wb_ir,
    output logic [15:0]         reg_C1,
    output logic                mem_err
);

    mem_fsm_e    fsm_q, fsm_d;
    logic [15:0] wb_ir_q, wb_ir_d;
    logic [15:0] reg_c1_q, reg_c1_d;

    logic run;
    logic access;
    logic tmr_inc;
    logic tmr_clr;
    logic tmo_hit;
    logic err_set;

    assign run    = (state == EXEC) & ~reset;
    assign access = is_load(mem_ir) | dw;

    assign dmem.d_req     = access & run;
    assign dmem.d_we      = dmem.d_req & dw;
    assign dmem.d_addr    = reg_C[ADDR_W-1:0];
    assign dmem.d_dataout = smdr1;
    assign stall          = dmem.d_req & ~dmem.d_ready;

    // Outside exec every register holds, so a WAIT is paused, not dropped.
    always_comb begin
        fsm_d    = fsm_q;
        wb_ir_d  = wb_ir_q;
        reg_c1_d = reg_c1_q;
        tmr_inc  = 1'b0;
        tmr_clr  = 1'b0;
        err_set  = 1'b0;
        if (state == EXEC) begin
            unique case (1'b1)
                !access: begin
                    wb_ir_d  = mem_ir;
                    reg_c1_d = reg_C;
                    fsm_d    = IDLE;
                end
                access && dmem.d_ready: begin
                    wb_ir_d  = mem_ir;
                    reg_c1_d = dw ? reg_C : dmem.d_datain;
                    fsm_d    = IDLE;
                    tmr_clr  = 1'b1;
                end
                access && !dmem.d_ready && (fsm_q == WAIT) && tmo_hit: begin
                    wb_ir_d  = NOP;
                    reg_c1_d = ERR_DATA;
                    fsm_d    = IDLE;
                    tmr_clr  = 1'b1;
                    err_set  = 1'b1;
                end
                default: begin
                    wb_ir_d = NOP;
                    fsm_d   = WAIT;
                    tmr_inc = (fsm_q == WAIT);
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q    <= IDLE;
            wb_ir_q  <= NOP;
            reg_c1_q <= 16'h0000;
        end else begin
            fsm_q    <= fsm_d;
            wb_ir_q  <= wb_ir_d;
            reg_c1_q <= reg_c1_d;
        end
    end

    assign wb_ir  = wb_ir_q;
    assign reg_C1 = reg_c1_q;

`ifdef MEM_TIMEOUT_EN
    logic mem_err_q, mem_err_d;

    mem_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .inc     (tmr_inc),
        .clr     (tmr_clr),
        .expired (tmo_hit)
    );

    always_comb begin
        mem_err_d = mem_err_q | err_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    // No timer: a wait never aborts and the error flag never rises.
    assign tmo_hit = 1'b0;
    assign mem_err = 1'b0;

    logic unused_tmo;
    assign unused_tmo = ^{tmr_inc, tmr_clr, err_set, TIMEOUT_CYC[0]};
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage and upstream of write-back.
- Consumes the execute stage's registered outputs (mem_ir, reg_C, dw, smdr1) and performs LOAD/STORE against a data memory with a ready handshake.
- Registers the instruction plus its result (wb_ir, reg_C1) for write-back.
- Raises a stall request while an access is outstanding.

Parameters:
- ADDR_W, 8: data-memory address width; address = reg_C[ADDR_W-1:0].
- TIMEOUT_CYC, 16: wait-cycle limit before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- state  in  1  CPU run state; stage advances only when state == `exec
- mem_ir  in  16  instruction from execute stage; [15:11] = opcode
- reg_C  in  16  ALU result / effective address from execute stage
- dw  in  1  store strobe from execute stage (1 = STORE)
- smdr1  in  16  store data from execute stage
- d_datain  in  16  read data from data memory
- d_ready  in  1  data memory completes current request this cycle
- d_req  out  1  data memory request (combinational)
- d_we  out  1  write enable, valid with d_req
- d_addr  out  ADDR_W  memory address, valid with d_req
- d_dataout  out  16  write data, valid with d_req & d_we
- stall  out  1  freeze request to fetch/decode/execute (combinational)
- wb_ir  out  16  instruction to write-back; 16'h0000 = NOP
- reg_C1  out  16  result to write-back: load data or pass-through reg_C
- mem_err  out  1  sticky access-timeout flag

Behaviour:
- access = (mem_ir[15:11] == `LOAD) | dw; opcodes come from define.v.
- Reset (asynchronous, active-high): wb_ir = 0, reg_C1 = 0, FSM = IDLE, wait counter = 0, mem_err = 0.
- While reset is high, d_req, d_we and stall are forced to 0.
- Combinational outputs:
  - d_req = access & (state == `exec) & ~reset.
  - d_we = d_req & dw.
  - d_addr = reg_C[ADDR_W-1:0].
  - d_dataout = smdr1.
  - stall = d_req & ~d_ready.
- state != `exec: every register holds, including FSM and counter. d_req = 0, so an outstanding access is paused, not dropped.
- FSM has two states, IDLE and WAIT. The following applies only while state == `exec.
- IDLE, non-access instruction (including NOP):
  - wb_ir <= mem_ir; reg_C1 <= reg_C.
  - Latency 1 cycle.
- IDLE, access with d_ready = 1: completes this cycle.
  - LOAD: reg_C1 <= d_datain.
  - STORE: reg_C1 <= reg_C.
  - wb_ir <= mem_ir; stay in IDLE.
- IDLE, access with d_ready = 0:
  - wb_ir <= 0 (bubble); reg_C1 holds; go to WAIT.
- WAIT, d_ready = 0:
  - wb_ir <= 0; counter increments.
  - Inputs are guaranteed stable because upstream is frozen by stall.
- WAIT, d_ready = 1: complete as in IDLE; counter <= 0; go to IDLE.
- Back-to-back accesses: each new access after completion re-enters IDLE and issues d_req on the following cycle, with no dead cycle.
- d_ready sampled while d_req = 0 is ignored.
- Reset asserted mid-WAIT: immediate return to IDLE. The pending access is abandoned, and any write never acknowledged is treated as not performed.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined, WAIT with counter == TIMEOUT_CYC-1 and d_ready = 0:
  - Abort: wb_ir <= 0, reg_C1 <= 16'hFFFF, mem_err <= 1 (sticky until reset).
  - Counter <= 0; go to IDLE.
  - The aborted instruction is dropped.
- Not defined: WAIT lasts indefinitely; no counter logic; mem_err tied to 0.

Decomposition:
- Shared definitions: opcode constants (`LOAD, `STORE, `exec) stay in define.v.
- FSM state encodings (IDLE = 1'b0, WAIT = 1'b1) and NOP = 16'h0000 go in define.v.
- Sub-module: mem_wait_timer, the counter plus compare. Instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Reset mid-WAIT: assert reset while d_ready = 0 -> FSM returns to IDLE, wb_ir = 0, reg_C1 = 0, stall = 0 immediately (asynchronous).
- ADD passthrough: mem_ir = ADD, reg_C = 16'h1234 -> next edge wb_ir = ADD, reg_C1 = 16'h1234, d_req = 0, stall = 0.
- LOAD with zero-wait memory: mem_ir = LOAD, reg_C = 16'h0042, d_ready = 1, d_datain = 16'hBEEF -> d_addr = 8'h42, d_we = 0, stall = 0; next edge wb_ir = LOAD, reg_C1 = 16'hBEEF.
- STORE with 3 wait cycles: dw = 1, smdr1 = 16'h5A5A, reg_C = 16'h0010, d_ready low for 3 cycles:
  - stall high for exactly 3 cycles; d_we = 1; d_dataout = 16'h5A5A.
  - wb_ir = 0 during the waits, then STORE with reg_C1 = 16'h0010.
- Pause: state leaves `exec during WAIT -> d_req = 0, registers hold; on return to `exec, d_req reasserts and the access completes normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYC = 4, d_ready held 0:
  - After 4 WAIT cycles: mem_err = 1, reg_C1 = 16'hFFFF, wb_ir = 0, FSM = IDLE.
  - mem_err stays 1 through later accesses.
